// File: rtl/riscv_mul_sched.sv
// Issue/writeback scheduler for the 2-stage RV32M multiplier.
// Optional perf counters are enabled with `define RISCV_MUL_SCHED_PERF_EN.
module riscv_mul_sched #(
  parameter int LATENCY = 2,
  parameter int XLEN    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [1:0]  issue_op,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_ra_idx,
  input  logic [4:0]  issue_rb_idx,
  output logic        mul_valid,
  output logic        mul_a_signed,
  output logic        mul_b_signed,
  output logic        mul_sel_hi,
  output logic        mul_hold,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  input  logic        wb_ready,
`ifdef RISCV_MUL_SCHED_PERF_EN
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall_hazard,
  output logic [31:0] perf_stall_hold,
`endif
  output logic [31:0] busy_rd
);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_t;

  generate
    if (LATENCY != 2 || XLEN != 32) begin : g_bad_cfg
      $error("riscv_mul_sched supports only LATENCY=2, XLEN=32");
    end
  endgenerate

  logic       s1_valid, s2_valid;
  logic [4:0] s1_rd, s2_rd;
  logic       hazard_a, hazard_b, hazard, fire;
  op_t        op;

  assign op = op_t'(issue_op);

  // No forwarding: a source matching s2_rd stalls even while s2 retires.
  assign hazard_a = (issue_ra_idx != 5'd0) &&
                    ((s1_valid && issue_ra_idx == s1_rd) ||
                     (s2_valid && issue_ra_idx == s2_rd));
  assign hazard_b = (issue_rb_idx != 5'd0) &&
                    ((s1_valid && issue_rb_idx == s1_rd) ||
                     (s2_valid && issue_rb_idx == s2_rd));
  assign hazard   = hazard_a | hazard_b;

  assign mul_hold    = s2_valid & ~wb_ready & ~flush;
  assign issue_ready = ~mul_hold & ~flush & ~hazard;
  assign fire        = issue_valid & issue_ready;
  assign mul_valid   = fire;

  always_comb begin
    mul_a_signed = 1'b0;
    mul_b_signed = 1'b0;
    mul_sel_hi   = 1'b0;
    if (fire) begin
      mul_a_signed = (op == OP_MULH) || (op == OP_MULHSU);
      mul_b_signed = (op == OP_MULH);
      mul_sel_hi   = (op != OP_MUL);
    end
  end

  assign wb_valid = s2_valid;
  assign wb_rd    = s2_rd;

  always_comb begin
    busy_rd = '0;
    if (s1_valid) busy_rd[s1_rd] = 1'b1;
    if (s2_valid) busy_rd[s2_rd] = 1'b1;
    busy_rd[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rd    <= '0;
      s2_valid <= 1'b0;
      s2_rd    <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (!mul_hold) begin
      s1_valid <= fire;
      s1_rd    <= issue_rd;
      s2_valid <= s1_valid;
      s2_rd    <= s1_rd;
    end
  end

`ifdef RISCV_MUL_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued       <= '0;
      perf_stall_hazard <= '0;
      perf_stall_hold   <= '0;
    end else begin
      if (fire)
        perf_issued <= perf_issued + 32'd1;
      if (issue_valid & hazard & ~mul_hold & ~flush)
        perf_stall_hazard <= perf_stall_hazard + 32'd1;
      if (issue_valid & mul_hold)
        perf_stall_hold <= perf_stall_hold + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_mul_sched.sv
// Directed self-checking bench for riscv_mul_sched; inputs change 1ns after
// posedge, outputs are sampled at negedge.
module tb_riscv_mul_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_op;
  logic [4:0]  issue_rd, issue_ra_idx, issue_rb_idx;
  logic        mul_valid, mul_a_signed, mul_b_signed, mul_sel_hi, mul_hold;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_ready;
  logic [31:0] busy_rd;
`ifdef RISCV_MUL_SCHED_PERF_EN
  logic [31:0] perf_issued, perf_stall_hazard, perf_stall_hold;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_mul_sched #(.LATENCY(2), .XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_op     (issue_op),
    .issue_rd     (issue_rd),
    .issue_ra_idx (issue_ra_idx),
    .issue_rb_idx (issue_rb_idx),
    .mul_valid    (mul_valid),
    .mul_a_signed (mul_a_signed),
    .mul_b_signed (mul_b_signed),
    .mul_sel_hi   (mul_sel_hi),
    .mul_hold     (mul_hold),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_ready     (wb_ready),
`ifdef RISCV_MUL_SCHED_PERF_EN
    .perf_issued       (perf_issued),
    .perf_stall_hazard (perf_stall_hazard),
    .perf_stall_hold   (perf_stall_hold),
`endif
    .busy_rd      (busy_rd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] rd,
                       input logic [4:0] ra, input logic [4:0] rb);
    issue_valid  = v;
    issue_op     = op;
    issue_rd     = rd;
    issue_ra_idx = ra;
    issue_rb_idx = rb;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    total++;
    if ({mul_valid, mul_a_signed, mul_b_signed, mul_sel_hi, mul_hold, wb_valid} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000000",
        {mul_valid, mul_a_signed, mul_b_signed, mul_sel_hi, mul_hold, wb_valid});
    end
    total++;
    if (wb_rd !== 5'd0 || busy_rd !== 32'h0) begin
      bad++; $display("FAIL reset_state wb_rd=%0d busy=%h exp 0/0", wb_rd, busy_rd);
    end
    total++;
    if (issue_ready !== 1'b1) begin
      bad++; $display("FAIL reset_issue_ready got=%b exp=1", issue_ready);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    drive(1'b1, 2'b00, 5'd5, 5'd1, 5'd2);
    @(negedge clk);
    total++;
    if ({mul_valid, mul_a_signed, mul_b_signed, mul_sel_hi} !== 4'b1000) begin
      bad++; $display("FAIL basic_issue got=%b exp=1000",
        {mul_valid, mul_a_signed, mul_b_signed, mul_sel_hi});
    end
    tick();
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    total++;
    if (busy_rd !== 32'h20 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL basic_c1 busy=%h wbv=%b exp 00000020/0", busy_rd, wb_valid);
    end
    tick();
    @(negedge clk);
    total++;
    if (busy_rd !== 32'h20 || wb_valid !== 1'b1 || wb_rd !== 5'd5) begin
      bad++; $display("FAIL basic_c2 busy=%h wbv=%b rd=%0d exp 00000020/1/5",
        busy_rd, wb_valid, wb_rd);
    end
    tick();
    @(negedge clk);
    total++;
    if (busy_rd !== 32'h0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL basic_c3 busy=%h wbv=%b exp 0/0", busy_rd, wb_valid);
    end
    tick();
  endtask

  task automatic test_modes();
    logic [1:0] ops  [3] = '{2'b01, 2'b10, 2'b11};
    logic [4:0] rds  [3] = '{5'd10, 5'd11, 5'd12};
    logic [2:0] trip [3] = '{3'b111, 3'b101, 3'b001};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, ops[i], rds[i], 5'(2*i+1), 5'(2*i+2));
      else       drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      if (i < 3) begin
        total++;
        if (issue_ready !== 1'b1 || mul_valid !== 1'b1 ||
            {mul_a_signed, mul_b_signed, mul_sel_hi} !== trip[i]) begin
          bad++; $display("FAIL modes_%0d rdy=%b v=%b mode=%b exp 1/1/%b", i,
            issue_ready, mul_valid, {mul_a_signed, mul_b_signed, mul_sel_hi}, trip[i]);
        end
      end
      if (i >= 2) begin
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== rds[i-2]) begin
          bad++; $display("FAIL modes_wb_c%0d wbv=%b rd=%0d exp 1/%0d", i,
            wb_valid, wb_rd, rds[i-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_hazard();
    drive(1'b1, 2'b00, 5'd7, 5'd1, 5'd2);
    tick();
    drive(1'b1, 2'b00, 5'd8, 5'd7, 5'd2);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++;
      if (issue_ready !== (c == 3) || mul_valid !== (c == 3)) begin
        bad++; $display("FAIL hazard_c%0d rdy=%b v=%b exp %b", c,
          issue_ready, mul_valid, (c == 3));
      end
      if (c == 2) begin
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd7) begin
          bad++; $display("FAIL hazard_retire wbv=%b rd=%0d exp 1/7", wb_valid, wb_rd);
        end
      end
      tick();
    end
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    tick(); tick();
  endtask

  task automatic test_rd_zero();
    drive(1'b1, 2'b00, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 2'b00, 5'd14, 5'd0, 5'd0);
    @(negedge clk);
    total++;
    if (issue_ready !== 1'b1 || busy_rd !== 32'h0) begin
      bad++; $display("FAIL rd0_nohazard rdy=%b busy=%h exp 1/0", issue_ready, busy_rd);
    end
    tick();
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd0 || busy_rd !== 32'h4000) begin
      bad++; $display("FAIL rd0_wb wbv=%b rd=%0d busy=%h exp 1/0/00004000",
        wb_valid, wb_rd, busy_rd);
    end
    tick(); tick();
  endtask

  task automatic test_hold();
    drive(1'b1, 2'b00, 5'd3, 5'd1, 5'd2);
    tick();
    drive(1'b1, 2'b00, 5'd4, 5'd5, 5'd6);
    tick();
    drive(1'b1, 2'b00, 5'd9, 5'd10, 5'd11);
    wb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (mul_hold !== 1'b1 || issue_ready !== 1'b0 || mul_valid !== 1'b0 ||
          wb_valid !== 1'b1 || wb_rd !== 5'd3) begin
        bad++; $display("FAIL hold_c%0d hold=%b rdy=%b v=%b wbv=%b rd=%0d exp 1/0/0/1/3",
          c, mul_hold, issue_ready, mul_valid, wb_valid, wb_rd);
      end
      tick();
    end
    wb_ready = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    total++;
    if (mul_hold !== 1'b0 || wb_valid !== 1'b1 || wb_rd !== 5'd3) begin
      bad++; $display("FAIL hold_rel_a hold=%b wbv=%b rd=%0d exp 0/1/3", mul_hold, wb_valid, wb_rd);
    end
    tick();
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd4) begin
      bad++; $display("FAIL hold_rel_b wbv=%b rd=%0d exp 1/4", wb_valid, wb_rd);
    end
    tick();
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b0) begin
      bad++; $display("FAIL hold_drain wbv=%b exp 0", wb_valid);
    end
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 2'b00, 5'd9, 5'd1, 5'd2);
    tick();
    drive(1'b1, 2'b00, 5'd13, 5'd3, 5'd4);
    tick();
    drive(1'b1, 2'b00, 5'd15, 5'd5, 5'd6);
    flush = 1'b1;
    wb_ready = 1'b0;
    @(negedge clk);
    total++;
    if (issue_ready !== 1'b0 || mul_hold !== 1'b0 || mul_valid !== 1'b0) begin
      bad++; $display("FAIL flush_cycle rdy=%b hold=%b v=%b exp 0/0/0",
        issue_ready, mul_hold, mul_valid);
    end
    tick();
    flush = 1'b0;
    wb_ready = 1'b1;
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b0 || busy_rd !== 32'h0 || issue_ready !== 1'b1 || mul_valid !== 1'b1) begin
      bad++; $display("FAIL flush_after wbv=%b busy=%h rdy=%b v=%b exp 0/0/1/1",
        wb_valid, busy_rd, issue_ready, mul_valid);
    end
    tick();
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    total++;
    if (busy_rd !== 32'h8000) begin
      bad++; $display("FAIL flush_resume busy=%h exp 00008000", busy_rd);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'b00, 5'd20, 5'd1, 5'd2);
    tick();
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (busy_rd !== 32'h0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid busy=%h wbv=%b exp 0/0", busy_rd, wb_valid);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (wb_valid !== 1'b0) begin
        bad++; $display("FAIL reset_mid_wb%0d wbv=%b exp 0", c, wb_valid);
      end
      tick();
    end
  endtask

`ifdef RISCV_MUL_SCHED_PERF_EN
  task automatic test_perf();
    do_reset();
    drive(1'b1, 2'b00, 5'd7, 5'd1, 5'd2);
    tick();
    drive(1'b1, 2'b00, 5'd8, 5'd7, 5'd2);
    tick(); tick(); tick();
    drive(1'b1, 2'b00, 5'd16, 5'd1, 5'd2);
    tick();
    drive(1'b1, 2'b00, 5'd17, 5'd1, 5'd2);
    tick();
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    total++;
    if (perf_issued !== 32'd4 || perf_stall_hazard !== 32'd2 || perf_stall_hold !== 32'd0) begin
      bad++; $display("FAIL perf_counts iss=%0d haz=%0d hold=%0d exp 4/2/0",
        perf_issued, perf_stall_hazard, perf_stall_hold);
    end
    force dut.perf_issued = 32'hFFFF_FFFF;
    #1;
    release dut.perf_issued;
    drive(1'b1, 2'b00, 5'd18, 5'd1, 5'd2);
    tick();
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    total++;
    if (perf_issued !== 32'd0) begin
      bad++; $display("FAIL perf_wrap got=%h exp 00000000", perf_issued);
    end
    tick(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_hazard();
    test_rd_zero();
    test_hold();
    test_flush();
    test_reset_mid();
`ifdef RISCV_MUL_SCHED_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
